// File: rtl/t0_stream_arbiter.sv
// Two-source stream arbiter feeding blade_top t0_data: post-reset holdoff, alternating
// grants per packet, and a forced rotation once a grant has carried MAX_BURST beats.
//   state  | meaning
//   HOLD   | post-reset settle, counts HOLDOFF cycles, nothing passes
//   IDLE   | one arbitration cycle between grants
//   GRANT0 | source 0 owns the merged stream
//   GRANT1 | source 1 owns the merged stream
module t0_stream_arbiter #(
  parameter int DATA_W    = 32,
  parameter int HOLDOFF   = 16,
  parameter int MAX_BURST = 64
) (
  input  logic              CLK,
  input  logic              MIB_MASTER_RESET,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [1:0]        o_grant,
  output logic              o_burst_cut
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {HOLD, IDLE, GRANT0, GRANT1} state_t;

  state_t            state, state_nxt;
  logic [7:0]        hold_cnt, hold_cnt_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic              last_served, last_served_nxt;
  logic              burst_cut, burst_cut_nxt;
  logic              xfer, burst_full;

  always_ff @(posedge CLK or posedge MIB_MASTER_RESET) begin
    if (MIB_MASTER_RESET) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      beat_cnt    <= '0;
      last_served <= 1'b1;
      burst_cut   <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      beat_cnt    <= beat_cnt_nxt;
      last_served <= last_served_nxt;
      burst_cut   <= burst_cut_nxt;
    end
  end

  // Datapath is a pure mux on state so an asynchronous reset clears it at once.
  always_comb begin
    m_data   = '0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    o_grant  = 2'b00;
    case (state)
      GRANT0: begin
        m_data   = s0_data;
        m_valid  = s0_valid;
        m_last   = s0_last;
        s0_ready = m_ready;
        o_grant  = 2'b01;
      end
      GRANT1: begin
        m_data   = s1_data;
        m_valid  = s1_valid;
        m_last   = s1_last;
        s1_ready = m_ready;
        o_grant  = 2'b10;
      end
      default: ;
    endcase
  end

  assign xfer        = m_valid & m_ready;
  assign burst_full  = (beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign o_burst_cut = burst_cut;

  always_comb begin
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    beat_cnt_nxt    = beat_cnt;
    last_served_nxt = last_served;
    burst_cut_nxt   = 1'b0;
    case (state)
      HOLD: begin
        if (hold_cnt == 8'(HOLDOFF - 1)) state_nxt = IDLE;
        else hold_cnt_nxt = hold_cnt + 8'd1;
      end
      IDLE: begin
        beat_cnt_nxt = '0;
        // With both requesting, the source not served last wins.
        if (i_enable) begin
          if (s0_valid && (!s1_valid || last_served)) state_nxt = GRANT0;
          else if (s1_valid) state_nxt = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          if (m_last || burst_full) begin
            state_nxt       = IDLE;
            last_served_nxt = (state == GRANT1);
            burst_cut_nxt   = !m_last;
          end
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

endmodule

// File: tb/tb_t0_stream_arbiter.sv
// Bench for t0_stream_arbiter: directed scenarios plus randomized packet traffic checked
// against a packet-level arbitration model (alternate on contention, split at MAX_BURST).
module tb_t0_stream_arbiter;
  localparam int DATA_W = 32, HOLDOFF = 16, MAX_BURST = 64, QD = 160;

  logic CLK = 1'b0;
  logic MIB_MASTER_RESET, i_enable;
  logic [DATA_W-1:0] s0_data, s1_data, m_data;
  logic s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic m_valid, m_last, m_ready, o_burst_cut;
  logic [1:0] o_grant;

  always #5 CLK = ~CLK;

  t0_stream_arbiter #(.DATA_W(DATA_W), .HOLDOFF(HOLDOFF), .MAX_BURST(MAX_BURST)) dut (
    .CLK(CLK), .MIB_MASTER_RESET(MIB_MASTER_RESET), .i_enable(i_enable),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .o_grant(o_grant), .o_burst_cut(o_burst_cut));

  int n_vec = 0, n_err = 0;
  logic [DATA_W-1:0] sq_data [2][QD];
  bit                sq_last [2][QD];
  int                sq_n    [2];
  logic [DATA_W-1:0] exp_data[$], got_data[$], tr_mdata[$], tr_sdata0[$];
  bit                exp_last[$], got_last[$], tr_sready0[$];
  int                exp_src[$], exp_len[$], cut_cyc[$], run_val[$], run_len[$];
  logic [1:0]        tr_grant[$];
  int                exp_cuts;
  int                stall_lo = -1, stall_hi = -1;

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_last = 1'b0; s0_data = '0;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = '0;
    m_ready = 1'b1; i_enable = 1'b1;
  endtask

  task automatic apply_reset();
    MIB_MASTER_RESET = 1'b1;
    @(negedge CLK);
    MIB_MASTER_RESET = 1'b0;
  endtask

  task automatic clear_sources();
    sq_n[0] = 0; sq_n[1] = 0;
  endtask

  task automatic add_packet(input int k, input int len);
    for (int i = 0; i < len; i++) begin
      sq_data[k][sq_n[k]] = $urandom();
      sq_last[k][sq_n[k]] = (i == len - 1);
      sq_n[k]++;
    end
  endtask

  // Packet-level model: a grant is a packet or a MAX_BURST slice of one; on contention
  // the source that did not own the previous grant goes next (source 1 owns it at reset).
  function automatic void build_expected();
    int p[2];
    int ls, pick, cnt;
    bit lb;
    exp_data.delete(); exp_last.delete(); exp_src.delete(); exp_len.delete();
    exp_cuts = 0; p[0] = 0; p[1] = 0; ls = 1;
    while (p[0] < sq_n[0] || p[1] < sq_n[1]) begin
      if (p[0] < sq_n[0] && p[1] < sq_n[1]) pick = 1 - ls;
      else pick = (p[0] < sq_n[0]) ? 0 : 1;
      cnt = 0;
      do begin
        lb = sq_last[pick][p[pick]];
        exp_data.push_back(sq_data[pick][p[pick]]);
        exp_last.push_back(lb);
        cnt++; p[pick]++;
      end while (!lb && cnt < MAX_BURST && p[pick] < sq_n[pick]);
      if (!lb) exp_cuts++;
      exp_src.push_back(pick); exp_len.push_back(cnt);
      ls = pick;
    end
  endfunction

  function automatic void grant_runs();
    run_val.delete(); run_len.delete();
    foreach (tr_grant[i]) begin
      if (i == 0 || tr_grant[i] !== tr_grant[i-1]) begin
        run_val.push_back(int'(tr_grant[i])); run_len.push_back(1);
      end else run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
    end
  endfunction

  // Drives both sources from sq_* and records the merged stream and per-cycle trace.
  task automatic run_traffic(input int max_cyc, input bit rnd);
    int p[2];
    int total;
    bit v[2];
    bit first;
    p[0] = 0; p[1] = 0; total = sq_n[0] + sq_n[1];
    got_data.delete(); got_last.delete(); tr_grant.delete(); tr_mdata.delete();
    tr_sdata0.delete(); tr_sready0.delete(); cut_cyc.delete();
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        first = (p[k] == 0) ? 1'b1 : sq_last[k][p[k]-1];
        v[k] = (p[k] < sq_n[k]) && (first || !rnd || ($urandom_range(3) != 0));
      end
      s0_valid = v[0]; s0_data = sq_data[0][p[0]]; s0_last = sq_last[0][p[0]];
      s1_valid = v[1]; s1_data = sq_data[1][p[1]]; s1_last = sq_last[1][p[1]];
      m_ready = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 :
                (rnd ? ($urandom_range(3) != 0) : 1'b1);
      #1;
      tr_grant.push_back(o_grant); tr_mdata.push_back(m_data);
      tr_sdata0.push_back(s0_data); tr_sready0.push_back(s0_ready);
      if (o_burst_cut) cut_cyc.push_back(cyc);
      if (m_valid && m_ready) begin got_data.push_back(m_data); got_last.push_back(m_last); end
      if (s0_valid && s0_ready) p[0]++;
      if (s1_valid && s1_ready) p[1]++;
      @(negedge CLK);
      if (got_data.size() >= total) break;
    end
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
    #1;
    tr_grant.push_back(o_grant);
    if (o_burst_cut) cut_cyc.push_back(tr_grant.size() - 1);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    idle_inputs();
    s0_valid = 1'b1; s0_data = 32'hA5A5_0001; s0_last = 1'b1;
    s1_valid = 1'b1; s1_data = 32'h5A5A_0002; s1_last = 1'b1;
    MIB_MASTER_RESET = 1'b1;
    @(negedge CLK); #1;
    n_vec++;
    if ({m_valid, m_last, s0_ready, s1_ready, o_grant, o_burst_cut} !== 7'd0 || m_data !== '0) begin
      n_err++; $display("FAIL reset_outputs: got grant=%b m_valid=%b m_data=%h, expected all zero", o_grant, m_valid, m_data);
    end
    @(negedge CLK);
    MIB_MASTER_RESET = 1'b0;
    for (int i = 0; i <= HOLDOFF; i++) begin
      #1; n_vec++;
      if (o_grant !== 2'b00 || m_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
        n_err++; $display("FAIL holdoff cycle %0d: got grant=%b m_valid=%b, expected 00/0", i, o_grant, m_valid);
      end
      @(negedge CLK);
    end
    #1; n_vec++;
    if (o_grant !== 2'b01 || m_data !== 32'hA5A5_0001 || m_valid !== 1'b1) begin
      n_err++; $display("FAIL first_grant: got grant=%b m_data=%h, expected 01 a5a50001", o_grant, m_data);
    end
    @(negedge CLK);
  endtask

  task automatic test_alternate();
    int gi;
    idle_inputs(); clear_sources();
    add_packet(0, 3); add_packet(0, 3); add_packet(1, 3); add_packet(1, 3);
    build_expected();
    apply_reset();
    run_traffic(400, 1'b0);
    n_vec++;
    if (got_data.size() != exp_data.size()) begin
      n_err++; $display("FAIL alt_count: got %0d beats, expected %0d", got_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) begin
      n_vec++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_err++; $display("FAIL alt_beat %0d: got %h, expected %h last=%b", i, (i < got_data.size()) ? got_data[i] : '0, exp_data[i], exp_last[i]);
      end
    end
    grant_runs(); gi = 0;
    for (int r = 0; r < run_val.size(); r++) begin
      if (run_val[r] != 0) begin
        n_vec++;
        if (gi >= exp_src.size() || run_val[r] !== (1 << exp_src[gi]) || run_len[r] != exp_len[gi]) begin
          n_err++; $display("FAIL alt_grant %0d: got %0d x%0d, expected %0d x%0d", gi, run_val[r], run_len[r], (gi < exp_src.size()) ? (1 << exp_src[gi]) : 0, (gi < exp_len.size()) ? exp_len[gi] : 0);
        end
        gi++;
      end else if (r > 0 && r < run_val.size() - 1) begin
        n_vec++;
        if (run_len[r] != 1) begin
          n_err++; $display("FAIL alt_bubble run %0d: got %0d idle cycles, expected 1", r, run_len[r]);
        end
      end
    end
    n_vec++;
    if (gi != exp_src.size()) begin
      n_err++; $display("FAIL alt_grant_count: got %0d, expected %0d", gi, exp_src.size());
    end
  endtask

  task automatic test_burst_cut();
    int gi;
    idle_inputs(); clear_sources();
    add_packet(0, 70); add_packet(1, 2);
    build_expected();
    apply_reset();
    run_traffic(600, 1'b0);
    foreach (exp_data[i]) begin
      n_vec++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_err++; $display("FAIL cut_beat %0d: got %h, expected %h", i, (i < got_data.size()) ? got_data[i] : '0, exp_data[i]);
      end
    end
    n_vec++;
    if (cut_cyc.size() != exp_cuts) begin
      n_err++; $display("FAIL cut_pulses: got %0d, expected %0d", cut_cyc.size(), exp_cuts);
    end
    if (cut_cyc.size() > 0) begin
      n_vec++;
      if (tr_grant[cut_cyc[0]-1] !== 2'b01 || tr_grant[cut_cyc[0]] !== 2'b00) begin
        n_err++; $display("FAIL cut_timing: got grant %b then %b, expected 01 then 00", tr_grant[cut_cyc[0]-1], tr_grant[cut_cyc[0]]);
      end
    end
    grant_runs(); gi = 0;
    for (int r = 0; r < run_val.size(); r++) begin
      if (run_val[r] != 0) begin
        n_vec++;
        if (gi >= exp_src.size() || run_val[r] !== (1 << exp_src[gi]) || run_len[r] != exp_len[gi]) begin
          n_err++; $display("FAIL cut_grant %0d: got %0d x%0d, expected %0d x%0d", gi, run_val[r], run_len[r], (gi < exp_src.size()) ? (1 << exp_src[gi]) : 0, (gi < exp_len.size()) ? exp_len[gi] : 0);
        end
        gi++;
      end
    end
    // Last beat landing exactly on MAX_BURST ends the packet normally.
    clear_sources(); add_packet(0, MAX_BURST);
    build_expected();
    apply_reset();
    run_traffic(400, 1'b0);
    n_vec++;
    if (got_data.size() != exp_data.size() || cut_cyc.size() != exp_cuts) begin
      n_err++; $display("FAIL cut_exact: got %0d beats %0d cuts, expected %0d beats %0d cuts", got_data.size(), cut_cyc.size(), exp_data.size(), exp_cuts);
    end
  endtask

  task automatic test_backpressure();
    idle_inputs(); clear_sources();
    add_packet(0, 8); add_packet(1, 3);
    build_expected();
    stall_lo = 22; stall_hi = 27;
    apply_reset();
    run_traffic(400, 1'b0);
    stall_lo = -1; stall_hi = -1;
    n_vec++;
    if (got_data.size() != exp_data.size()) begin
      n_err++; $display("FAIL bp_count: got %0d beats, expected %0d", got_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) begin
      n_vec++;
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        n_err++; $display("FAIL bp_beat %0d: got %h, expected %h", i, (i < got_data.size()) ? got_data[i] : '0, exp_data[i]);
      end
    end
    for (int c = 22; c < 27; c++) begin
      n_vec++;
      if (tr_grant[c] !== 2'b01 || tr_sready0[c] !== 1'b0 || tr_mdata[c] !== tr_sdata0[c]) begin
        n_err++; $display("FAIL bp_stall cyc %0d: got grant=%b s0_ready=%b m_data=%h, expected 01 0 %h", c, tr_grant[c], tr_sready0[c], tr_mdata[c], tr_sdata0[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    s1_valid = 1'b1; s1_data = 32'h1111_0000; s1_last = 1'b0;
    apply_reset();
    for (int i = 0; i < 40 && o_grant !== 2'b10; i++) @(negedge CLK);
    n_vec++;
    if (o_grant !== 2'b10) begin
      n_err++; $display("FAIL ares_grant_wait: got %b, expected 10", o_grant);
    end
    @(negedge CLK); s1_data = 32'h1111_0001;
    @(negedge CLK); s1_data = 32'h1111_0002;
    #2;
    MIB_MASTER_RESET = 1'b1;
    #1; n_vec++;
    if (m_valid !== 1'b0 || s1_ready !== 1'b0 || o_grant !== 2'b00 || m_data !== '0) begin
      n_err++; $display("FAIL ares_drop: got m_valid=%b s1_ready=%b grant=%b m_data=%h, expected zeros", m_valid, s1_ready, o_grant, m_data);
    end
    @(negedge CLK);
    MIB_MASTER_RESET = 1'b0;
    for (int i = 0; i <= HOLDOFF; i++) begin
      #1; n_vec++;
      if (o_grant !== 2'b00) begin
        n_err++; $display("FAIL ares_hold cycle %0d: got %b, expected 00", i, o_grant);
      end
      @(negedge CLK);
    end
    #1; n_vec++;
    if (o_grant !== 2'b10) begin
      n_err++; $display("FAIL ares_regrant: got %b, expected 10", o_grant);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_enable_drop();
    int idx;
    idle_inputs();
    s1_valid = 1'b1; s1_data = 32'h0000_5555; s1_last = 1'b1;
    apply_reset();
    idx = 0;
    for (int c = 0; c < 60 && idx < 4; c++) begin
      s0_valid = 1'b1; s0_data = 32'hE000_0000 + 32'(idx); s0_last = (idx == 3);
      #1;
      if (s0_valid && s0_ready) begin
        n_vec++;
        if (m_data !== 32'hE000_0000 + 32'(idx) || m_last !== (idx == 3)) begin
          n_err++; $display("FAIL en_beat %0d: got %h last=%b, expected %h", idx, m_data, m_last, 32'hE000_0000 + 32'(idx));
        end
        idx++;
        if (idx == 1) i_enable = 1'b0;
      end
      @(negedge CLK);
    end
    n_vec++;
    if (idx != 4) begin
      n_err++; $display("FAIL en_complete: got %0d beats, expected 4", idx);
    end
    s0_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1; n_vec++;
      if (o_grant !== 2'b00 || m_valid !== 1'b0) begin
        n_err++; $display("FAIL en_hold cycle %0d: got grant=%b, expected 00", i, o_grant);
      end
      @(negedge CLK);
    end
    i_enable = 1'b1;
    @(negedge CLK); #1; n_vec++;
    if (o_grant !== 2'b10 || m_data !== 32'h0000_5555) begin
      n_err++; $display("FAIL en_resume: got grant=%b m_data=%h, expected 10 00005555", o_grant, m_data);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_random();
    int gi;
    for (int it = 0; it < 4; it++) begin
      idle_inputs(); clear_sources();
      for (int k = 0; k < 2; k++)
        for (int n = $urandom_range(6, 1); n > 0; n--) add_packet(k, $urandom_range(5, 1));
      build_expected();
      apply_reset();
      run_traffic(2000, 1'b1);
      n_vec++;
      if (got_data.size() != exp_data.size() || cut_cyc.size() != exp_cuts) begin
        n_err++; $display("FAIL rnd%0d_count: got %0d beats %0d cuts, expected %0d beats %0d cuts", it, got_data.size(), cut_cyc.size(), exp_data.size(), exp_cuts);
      end
      foreach (exp_data[i]) begin
        n_vec++;
        if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
          n_err++; $display("FAIL rnd%0d_beat %0d: got %h, expected %h", it, i, (i < got_data.size()) ? got_data[i] : '0, exp_data[i]);
        end
      end
      grant_runs(); gi = 0;
      for (int r = 0; r < run_val.size(); r++) begin
        if (run_val[r] != 0) begin
          n_vec++;
          if (gi >= exp_src.size() || run_val[r] !== (1 << exp_src[gi])) begin
            n_err++; $display("FAIL rnd%0d_grant %0d: got %0d, expected %0d", it, gi, run_val[r], (gi < exp_src.size()) ? (1 << exp_src[gi]) : 0);
          end
          gi++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_burst_cut();
    test_backpressure();
    test_async_reset();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/t0_stream_arbiter.md
T0_STREAM_ARBITER -- requirements
Module: t0_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream data width in bits.
REQ-002 SHALL have parameter HOLDOFF, default 16, post-reset idle cycles before any grant (range 1..255).
REQ-003 SHALL have parameter MAX_BURST, default 64, maximum beats per grant before forced rotation (range 2..1024).
REQ-004 SHALL have ports, one per line:
- CLK  in  1  single clock, all logic rising-edge.
- MIB_MASTER_RESET  in  1  reset, asynchronous, active-high.
- i_enable  in  1  permits new grants when high.
- s0_data  in  DATA_W  source 0 (ADC) data.
- s0_valid  in  1  source 0 valid.
- s0_last  in  1  source 0 end of packet.
- s0_ready  out  1  source 0 ready.
- s1_data  in  DATA_W  source 1 (test/loopback) data.
- s1_valid  in  1  source 1 valid.
- s1_last  in  1  source 1 end of packet.
- s1_ready  out  1  source 1 ready.
- m_data  out  DATA_W  merged stream to blade_top t0_data.
- m_valid  out  1  merged valid.
- m_last  out  1  merged last.
- m_ready  in  1  downstream ready.
- o_grant  out  2  one-hot current grant (bit k = source k), 0 when none.
- o_burst_cut  out  1  one-cycle pulse on forced rotation.

Function
REQ-005 SHALL implement states HOLD, IDLE, GRANT0, GRANT1.
REQ-006 Transfer on source k SHALL be defined as sk_valid & sk_ready at a rising CLK edge.
REQ-007 HOLD SHALL count 0..HOLDOFF-1 in an 8-bit counter, then enter IDLE; no grant, all readies 0.
REQ-008 IDLE with i_enable=1 SHALL select the next grant: only s0_valid -> GRANT0; only s1_valid -> GRANT1; both -> source != last_served; neither or i_enable=0 -> stay IDLE.
REQ-009 Arbitration SHALL cost exactly one IDLE cycle between grants; no beat passes in IDLE.
REQ-010 In GRANTk, m_data/m_valid/m_last SHALL equal sk_data/sk_valid/sk_last combinationally, and sk_ready SHALL equal m_ready; the other source's ready SHALL be 0.
REQ-011 Outside GRANT states, m_valid, m_last, s0_ready, s1_ready SHALL be 0 and m_data SHALL be all zeros.
REQ-012 A beat counter SHALL clear on entry to GRANTk and increment per transfer.
REQ-013 GRANTk SHALL exit to IDLE on a transfer with sk_last=1; last_served <= k.
REQ-014 GRANTk SHALL exit to IDLE on the transfer that makes the beat count equal MAX_BURST when sk_last=0; o_burst_cut pulses high the following cycle; last_served <= k.
REQ-015 If last and the MAX_BURST beat coincide, exit SHALL follow REQ-013 and o_burst_cut SHALL stay 0.
REQ-016 i_enable falling during GRANTk SHALL NOT end the grant; the packet completes per REQ-013/014 and IDLE then holds.
REQ-017 sk_valid deasserting mid-grant SHALL NOT release the grant.
REQ-018 o_grant SHALL be 2'b01 in GRANT0, 2'b10 in GRANT1, else 2'b00.

Reset
REQ-019 MIB_MASTER_RESET high SHALL immediately force state HOLD, HOLD counter 0, beat counter 0, last_served=1, o_burst_cut=0, hence all outputs 0 in the same cycle, including mid-packet.
REQ-020 After reset release, first grant SHALL occur no earlier than HOLDOFF+1 cycles; with both sources valid it SHALL go to source 0.

Verification
REQ-021 Reset release, both valid, HOLDOFF=16 -> o_grant=00 for 16 cycles, IDLE 1 cycle, then o_grant=01.
REQ-022 Both sources send 3-beat packets continuously, m_ready=1 -> grants alternate 01,10,01; one IDLE bubble between packets; m_data matches source order.
REQ-023 Source 0 streams 70 beats with last=0, MAX_BURST=64, s1 valid -> 64 beats pass, o_burst_cut pulses once, next grant 10.
REQ-024 m_ready=0 for 5 cycles mid-packet -> sk_ready=0, m_data held equal to source, no beat lost or duplicated.
REQ-025 MIB_MASTER_RESET asserted asynchronously at beat 2 of a GRANT1 packet -> m_valid, s1_ready, o_grant drop to 0 before next edge; HOLD restarts.
REQ-026 i_enable dropped at beat 1 of 4-beat packet -> packet completes, then o_grant=00 until i_enable=1.
